// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi
// Brief    : Multi-channel PWM generator with prescaler, edge/center modes and
//            double-buffered configuration adopted at each period boundary.
// Revision : 1.0
// ============================================================================
module pwm_multi #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int DIV_W    = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS*CNT_W-1:0] cfg_high,
    input  logic [CHANNELS*CNT_W-1:0] cfg_period,
    input  logic [CHANNELS*DIV_W-1:0] cfg_div,
    input  logic [CHANNELS-1:0]       cfg_center,
    input  logic [CHANNELS-1:0]       cfg_invert,
    input  logic                      cfg_commit,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic [CHANNELS-1:0]       period_start,
    output logic [CHANNELS-1:0]       pending
);

    typedef struct packed {
        logic [CNT_W-1:0] high;
        logic [CNT_W-1:0] period;
        logic [DIV_W-1:0] div;
        logic             center;
        logic             invert;
    } cfg_t;

    localparam logic [CNT_W:0] ONE_X = (CNT_W+1)'(1);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        cfg_t             cfg_in;
        cfg_t             act_q, act_d, pend_q, pend_d, eff;
        logic             flag_q, flag_d;
        logic [DIV_W-1:0] pre_q, pre_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             dir_q, dir_d;       // 0 = counting up
        logic             out_q, out_d;
        logic             ps_q, ps_d;
        logic             idle_apply, tick, boundary, active;
        logic [CNT_W-1:0] per_eff;
        logic [CNT_W:0]   per_x, pm1_x, thr_x, cnt_x, high_x;

        assign cfg_in = {cfg_high[CNT_W*i +: CNT_W], cfg_period[CNT_W*i +: CNT_W],
                         cfg_div[DIV_W*i +: DIV_W], cfg_center[i], cfg_invert[i]};

        always_comb begin
            // An idle channel adopts its pending config immediately, so this
            // cycle is already evaluated under the new settings.
            idle_apply = (act_q.div == '0) && flag_q;
            eff        = idle_apply ? pend_q : act_q;
            per_eff    = (eff.period == '0) ? CNT_W'(1) : eff.period;
            per_x      = {1'b0, per_eff};
            high_x     = {1'b0, eff.high};
            pm1_x      = per_x - ONE_X;
            thr_x      = per_x - high_x;
            cnt_x      = {1'b0, cnt_q};
            tick       = (pre_q == eff.div - DIV_W'(1));
            if (eff.center)
                active = (high_x >= per_x) || (cnt_x >= thr_x);
            else
                active = (cnt_x < high_x);

            pre_d    = pre_q;
            cnt_d    = cnt_q;
            dir_d    = dir_q;
            boundary = 1'b0;
            act_d    = act_q;
            pend_d   = pend_q;
            flag_d   = flag_q;
            out_d    = eff.invert;
            ps_d     = 1'b0;

            if (eff.div == '0) begin
                pre_d = '0;
                cnt_d = '0;
                dir_d = 1'b0;
            end else begin
                out_d = active ^ eff.invert;
                ps_d  = (pre_q == '0) && (cnt_q == '0) && !dir_q;
                if (tick) begin
                    pre_d = '0;
                    if (!eff.center) begin
                        if (cnt_x == pm1_x) begin
                            cnt_d    = '0;
                            boundary = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (!dir_q) begin
                        if (cnt_x == pm1_x)
                            dir_d = 1'b1;
                        else
                            cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        if (cnt_q == '0) begin
                            dir_d    = 1'b0;
                            boundary = 1'b1;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end else begin
                    pre_d = pre_q + DIV_W'(1);
                end
            end

            if (idle_apply || (flag_q && boundary)) begin
                act_d  = pend_q;
                flag_d = 1'b0;
            end
            // A commit coinciding with an application re-arms the shadow.
            if (cfg_commit) begin
                pend_d = cfg_in;
                flag_d = 1'b1;
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                act_q  <= '0;
                pend_q <= '0;
                flag_q <= 1'b0;
                pre_q  <= '0;
                cnt_q  <= '0;
                dir_q  <= 1'b0;
                out_q  <= 1'b0;
                ps_q   <= 1'b0;
            end else begin
                act_q  <= act_d;
                pend_q <= pend_d;
                flag_q <= flag_d;
                pre_q  <= pre_d;
                cnt_q  <= cnt_d;
                dir_q  <= dir_d;
                out_q  <= out_d;
                ps_q   <= ps_d;
            end
        end

        assign pwm_out[i]      = out_q;
        assign period_start[i] = ps_q;
        assign pending[i]      = flag_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_multi
// Brief    : Self-checking bench for pwm_multi against a period-position model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_pwm_multi;
    localparam int CH = 4;
    localparam int CW = 16;
    localparam int DW = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [CH*CW-1:0] cfg_high   = '0;
    logic [CH*CW-1:0] cfg_period = '0;
    logic [CH*DW-1:0] cfg_div    = '0;
    logic [CH-1:0]   cfg_center = '0;
    logic [CH-1:0]   cfg_invert = '0;
    logic            cfg_commit = 1'b0;
    logic [CH-1:0]   pwm_out, period_start, pending;

    int vectors     = 0;
    int miscompares = 0;

    pwm_multi #(.CHANNELS(CH), .CNT_W(CW), .DIV_W(DW)) dut (
        .clock(clock), .reset(reset),
        .cfg_high(cfg_high), .cfg_period(cfg_period), .cfg_div(cfg_div),
        .cfg_center(cfg_center), .cfg_invert(cfg_invert), .cfg_commit(cfg_commit),
        .pwm_out(pwm_out), .period_start(period_start), .pending(pending)
    );

    always #5 clock = ~clock;

    // Reference model: each running channel is a position within a period of
    // div*L clocks (L = P ticks edge, 2P ticks center).
    typedef struct packed { int high; int period; int div; bit center; bit invert; } mcfg_t;
    mcfg_t m_act [CH];
    mcfg_t m_pend[CH];
    bit    m_flag[CH];
    int    m_pos [CH];
    logic [CH-1:0] exp_pwm = '0, exp_ps = '0, exp_pend = '0;

    function automatic mcfg_t input_cfg(int ch);
        mcfg_t r;
        r.high   = int'(cfg_high[CW*ch +: CW]);
        r.period = int'(cfg_period[CW*ch +: CW]);
        r.div    = int'(cfg_div[DW*ch +: DW]);
        r.center = cfg_center[ch];
        r.invert = cfg_invert[ch];
        return r;
    endfunction

    function automatic void model_reset();
        for (int ch = 0; ch < CH; ch++) begin
            m_act[ch] = '0; m_pend[ch] = '0; m_flag[ch] = 1'b0; m_pos[ch] = 0;
        end
        exp_pwm = '0; exp_ps = '0; exp_pend = '0;
    endfunction

    function automatic void model_step();
        for (int ch = 0; ch < CH; ch++) begin
            mcfg_t e;
            int    p, l, k, c;
            bit    on;
            e = m_act[ch];
            if (m_act[ch].div == 0 && m_flag[ch]) begin
                e = m_pend[ch]; m_act[ch] = m_pend[ch]; m_flag[ch] = 1'b0; m_pos[ch] = 0;
            end
            if (e.div == 0) begin
                exp_pwm[ch] = e.invert; exp_ps[ch] = 1'b0; m_pos[ch] = 0;
            end else begin
                p  = (e.period == 0) ? 1 : e.period;
                l  = e.center ? 2 * p : p;
                k  = m_pos[ch] / e.div;
                c  = !e.center ? k : ((k < p) ? k : 2 * p - 1 - k);
                on = e.center ? (c >= p - e.high) : (c < e.high);
                exp_pwm[ch] = on ^ e.invert;
                exp_ps[ch]  = (m_pos[ch] == 0);
                m_pos[ch]++;
                if (m_pos[ch] == e.div * l) begin
                    m_pos[ch] = 0;
                    if (m_flag[ch]) begin m_act[ch] = m_pend[ch]; m_flag[ch] = 1'b0; end
                end
            end
            if (cfg_commit) begin m_pend[ch] = input_cfg(ch); m_flag[ch] = 1'b1; end
            exp_pend[ch] = m_flag[ch];
        end
    endfunction

    task automatic tick();
        if (reset) model_reset(); else model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_cfg(int ch, int h, int p, int d, bit c, bit inv);
        cfg_high[CW*ch +: CW]   = CW'(h);
        cfg_period[CW*ch +: CW] = CW'(p);
        cfg_div[DW*ch +: DW]    = DW'(d);
        cfg_center[ch]          = c;
        cfg_invert[ch]          = inv;
    endtask

    task automatic commit_tick();
        cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(); reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cfg_commit = 1'b1;
        for (int ch = 0; ch < CH; ch++) set_cfg(ch, 2, 4, 1, 0, 1);
        tick(); tick();
        reset = 1'b0; cfg_commit = 1'b0;
        vectors++;
        if ({pwm_out, period_start, pending} !== '0) begin
            miscompares++;
            $display("FAIL reset_state got pwm=%b ps=%b pend=%b want all 0", pwm_out, period_start, pending);
        end
        for (int n = 0; n < 4; n++) begin
            tick();
            vectors++;
            if ({pwm_out, period_start, pending} !== {exp_pwm, exp_ps, exp_pend}) begin
                miscompares++;
                $display("FAIL reset_idle n=%0d got pwm=%b ps=%b pend=%b want pwm=%b ps=%b pend=%b",
                         n, pwm_out, period_start, pending, exp_pwm, exp_ps, exp_pend);
            end
        end
    endtask

    task automatic test_edge_idle();
        logic [3:0] pat = 4'b0001;
        do_reset();
        for (int ch = 0; ch < CH; ch++) set_cfg(ch, 1, 4, 1, 0, 0);
        commit_tick();
        vectors++;
        if (pending !== '1 || pwm_out !== '0) begin
            miscompares++;
            $display("FAIL edge_pending got pend=%b pwm=%b want pend=1111 pwm=0000", pending, pwm_out);
        end
        for (int n = 0; n < 12; n++) begin
            tick();
            vectors++;
            if (pwm_out[0] !== pat[n % 4] || period_start[0] !== (n % 4 == 0) || pending[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL edge_pattern n=%0d got pwm=%b ps=%b pend=%b want pwm=%b ps=%b pend=0",
                         n, pwm_out[0], period_start[0], pending[0], pat[n % 4], (n % 4 == 0));
            end
            vectors++;
            if ({pwm_out, period_start, pending} !== {exp_pwm, exp_ps, exp_pend}) begin
                miscompares++;
                $display("FAIL edge_model n=%0d got pwm=%b ps=%b pend=%b want pwm=%b ps=%b pend=%b",
                         n, pwm_out, period_start, pending, exp_pwm, exp_ps, exp_pend);
            end
        end
    endtask

    task automatic test_prescale();
        logic [5:0] pat = 6'b000111;
        do_reset();
        for (int ch = 0; ch < CH; ch++) set_cfg(ch, 1, 2, 3, 0, 0);
        commit_tick();
        for (int n = 0; n < 18; n++) begin
            tick();
            vectors++;
            if (pwm_out[0] !== pat[n % 6] || period_start[0] !== (n % 6 == 0)) begin
                miscompares++;
                $display("FAIL prescale n=%0d got pwm=%b ps=%b want pwm=%b ps=%b",
                         n, pwm_out[0], period_start[0], pat[n % 6], (n % 6 == 0));
            end
        end
    endtask

    task automatic test_center();
        logic [5:0] pat = 6'b001100;
        bit seen = 1'b0;
        do_reset();
        for (int ch = 0; ch < CH; ch++) set_cfg(ch, 1, 3, 1, 1, 0);
        commit_tick();
        for (int n = 0; n < 12; n++) begin
            tick();
            vectors++;
            if (pwm_out[0] !== pat[n % 6] || period_start[0] !== (n % 6 == 0)) begin
                miscompares++;
                $display("FAIL center n=%0d got pwm=%b ps=%b want pwm=%b ps=%b",
                         n, pwm_out[0], period_start[0], pat[n % 6], (n % 6 == 0));
            end
        end
        for (int ch = 0; ch < CH; ch++) set_cfg(ch, 3, 3, 1, 1, 0);
        commit_tick();
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            seen = period_start[0];
            vectors++;
            if ({pwm_out, period_start, pending} !== {exp_pwm, exp_ps, exp_pend}) begin
                miscompares++;
                $display("FAIL center_model n=%0d got pwm=%b ps=%b pend=%b want pwm=%b ps=%b pend=%b",
                         n, pwm_out, period_start, pending, exp_pwm, exp_ps, exp_pend);
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL center_wait got no period_start want one within 20 clocks");
        end
        for (int n = 0; n < 12; n++) begin
            if (n > 0) tick();
            vectors++;
            if (pwm_out[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL center_full n=%0d got pwm=%b want 1", n, pwm_out[0]);
            end
        end
    endtask

    task automatic test_shadow();
        logic [3:0] pat = 4'b0111;
        logic [2:0] old_pend = 3'b011;
        do_reset();
        for (int ch = 0; ch < CH; ch++) set_cfg(ch, 1, 4, 1, 0, 0);
        commit_tick();
        tick();
        for (int ch = 0; ch < CH; ch++) set_cfg(ch, 3, 4, 1, 0, 0);
        commit_tick();
        for (int n = 0; n < 3; n++) begin
            if (n > 0) tick();
            vectors++;
            if (pending[0] !== old_pend[n] || pwm_out[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL shadow_old n=%0d got pend=%b pwm=%b want pend=%b pwm=0",
                         n, pending[0], pwm_out[0], old_pend[n]);
            end
        end
        for (int n = 0; n < 8; n++) begin
            tick();
            vectors++;
            if (pwm_out[0] !== pat[n % 4] || period_start[0] !== (n % 4 == 0) || pending[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL shadow_new n=%0d got pwm=%b ps=%b pend=%b want pwm=%b ps=%b pend=0",
                         n, pwm_out[0], period_start[0], pending[0], pat[n % 4], (n % 4 == 0));
            end
        end
    endtask

    task automatic test_corners();
        bit cleared = 1'b0;
        do_reset();
        set_cfg(0, 0, 0, 1, 0, 0);
        set_cfg(1, 5, 0, 2, 0, 0);
        set_cfg(2, 3, 5, 0, 0, 1);
        set_cfg(3, 2, 3, 1, 0, 0);
        commit_tick();
        tick();
        for (int n = 0; n < 8; n++) begin
            tick();
            vectors++;
            if (pwm_out[2:0] !== 3'b110) begin
                miscompares++;
                $display("FAIL corner_levels n=%0d got pwm[2:0]=%b want 110", n, pwm_out[2:0]);
            end
            vectors++;
            if ({pwm_out, period_start, pending} !== {exp_pwm, exp_ps, exp_pend}) begin
                miscompares++;
                $display("FAIL corner_model n=%0d got pwm=%b ps=%b pend=%b want pwm=%b ps=%b pend=%b",
                         n, pwm_out, period_start, pending, exp_pwm, exp_ps, exp_pend);
            end
        end
        set_cfg(3, 2, 3, 0, 0, 0);
        commit_tick();
        for (int n = 0; n < 10 && !cleared; n++) begin
            tick();
            cleared = !pending[3];
        end
        vectors++;
        if (!cleared) begin
            miscompares++;
            $display("FAIL corner_div0_apply got pend=%b want 0 within 10 clocks", pending[3]);
        end
        for (int n = 0; n < 6; n++) begin
            tick();
            vectors++;
            if (pwm_out[3] !== 1'b0 || period_start[3] !== 1'b0 || pending[3] !== 1'b0) begin
                miscompares++;
                $display("FAIL corner_div0_idle n=%0d got pwm=%b ps=%b pend=%b want 0 0 0",
                         n, pwm_out[3], period_start[3], pending[3]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int ch = 0; ch < CH; ch++) set_cfg(ch, 10, 50, 1, 0, ch[0]);
        commit_tick();
        tick(); tick();
        for (int ch = 0; ch < CH; ch++) set_cfg(ch, 20, 50, 1, 0, 1);
        commit_tick();
        vectors++;
        if (pending !== '1) begin
            miscompares++;
            $display("FAIL resetmid_pending got pend=%b want 1111", pending);
        end
        reset = 1'b1; tick(); reset = 1'b0;
        for (int n = 0; n < 10; n++) begin
            vectors++;
            if ({pwm_out, period_start, pending} !== '0) begin
                miscompares++;
                $display("FAIL resetmid_idle n=%0d got pwm=%b ps=%b pend=%b want all 0",
                         n, pwm_out, period_start, pending);
            end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                for (int ch = 0; ch < CH; ch++)
                    set_cfg(ch, int'($urandom_range(0, 7)), int'($urandom_range(0, 6)),
                            ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3)),
                            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                cfg_commit = 1'b1;
            end
            reset = ($urandom_range(0, 499) == 0);
            tick();
            cfg_commit = 1'b0;
            reset = 1'b0;
            vectors++;
            if ({pwm_out, period_start, pending} !== {exp_pwm, exp_ps, exp_pend}) begin
                miscompares++;
                $display("FAIL random n=%0d got pwm=%b ps=%b pend=%b want pwm=%b ps=%b pend=%b",
                         n, pwm_out, period_start, pending, exp_pwm, exp_ps, exp_pend);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_edge_idle();
        test_prescale();
        test_center();
        test_shadow();
        test_corners();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
